// File: rtl/pipe_stage.sv
// Elastic valid/ready pipeline register with a 2-entry skid buffer (main + skid).
// Optional synchronous flush is compiled in when PIPE_STAGE_FLUSH_EN is defined.
module pipe_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef PIPE_STAGE_FLUSH_EN
  input  logic             flush,
`endif
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             load_main_in, load_main_skid, load_skid_in;
  logic             accept, release_beat, flush_now;

  // Handshake signals decode only registered state, so out_ready never reaches in_ready
  assign in_ready     = (state_q != FULL) & ~rst;
  assign out_valid    = (state_q != EMPTY);
  assign occupancy    = state_q;
  assign out_data     = main_q;
  assign accept       = in_valid & in_ready;
  assign release_beat = out_valid & out_ready;

`ifdef PIPE_STAGE_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush_now) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (accept && release_beat) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid_in = 1'b1;
            state_d      = FULL;
          end else if (release_beat) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (release_beat) begin
            load_main_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid_in) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Directed self-checking bench for pipe_stage: reset, streaming, stall, flush,
// async reset mid-stall, plus a short random back-pressure run with a scoreboard.
module tb_pipe_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
`ifdef PIPE_STAGE_FLUSH_EN
  logic        flush;
`endif

  int checks = 0;
  int errors = 0;

  pipe_stage #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef PIPE_STAGE_FLUSH_EN
    .flush     (flush),
`endif
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Passing check_data=0 skips out_data where it is a don't-care
  task automatic checkOutput(input string tag, input logic ev, input logic [31:0] ed,
                             input logic [1:0] eo, input logic er, input bit check_data);
    checkBit({tag, ".out_valid"}, out_valid, ev);
    checkBit({tag, ".in_ready"}, in_ready, er);
    checks++;
    assert (occupancy === eo) else begin
      errors++;
      $error("[TB] FAIL %s.occupancy observed %0d expected %0d", tag, occupancy, eo);
    end
    if (check_data) begin
      checks++;
      assert (out_data === ed) else begin
        errors++;
        $error("[TB] FAIL %s.out_data observed %h expected %h", tag, out_data, ed);
      end
    end
  endtask

  initial begin
    logic [31:0] sb[$];
    logic [31:0] next_val;
    logic [31:0] exp_d;
    int          model_occ;
    logic        iv, ordy, exp_rdy, acc, rel;

    rst = 1'b1;
`ifdef PIPE_STAGE_FLUSH_EN
    flush = 1'b0;
`endif
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0);

    // Reset held for three cycles with a beat pending upstream
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("reset", 1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
    end
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("post_reset", 1'b0, 32'h0, 2'd0, 1'b1, 1'b1);

    // Back-to-back streaming with out_ready high
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b1);
      tick();
      checkOutput($sformatf("stream%0d", i), 1'b1, 32'(i), 2'd1, 1'b1, 1'b1);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("stream_drain", 1'b0, 32'h0, 2'd0, 1'b1, 1'b0);

    // Stall: A and B held, C refused
    applyStimulus(1'b1, 32'hA, 1'b0);
    tick();
    checkOutput("stall_a", 1'b1, 32'hA, 2'd1, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'hB, 1'b0);
    tick();
    checkOutput("stall_full", 1'b1, 32'hA, 2'd2, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hC, 1'b0);
    tick();
    checkOutput("stall_c_refused", 1'b1, 32'hA, 2'd2, 1'b0, 1'b1);
    out_ready = 1'b1;
    #1;
    checkBit("ready_indep_full", in_ready, 1'b0);
    applyStimulus(1'b1, 32'hC, 1'b1);
    tick();
    checkOutput("recover_b", 1'b1, 32'hB, 2'd1, 1'b1, 1'b1);
    out_ready = 1'b0;
    #1;
    checkBit("ready_indep_one", in_ready, 1'b1);
    applyStimulus(1'b1, 32'hC, 1'b1);
    tick();
    checkOutput("recover_c", 1'b1, 32'hC, 2'd1, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("recover_drain", 1'b0, 32'h0, 2'd0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_FLUSH_EN
    applyStimulus(1'b1, 32'h11, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h22, 1'b0);
    tick();
    checkOutput("flush_pre", 1'b1, 32'h11, 2'd2, 1'b0, 1'b1);
    flush = 1'b1;
    applyStimulus(1'b1, 32'h33, 1'b0);
    tick();
    flush = 1'b0;
    checkOutput("flush_empty", 1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h44, 1'b1);
    tick();
    checkOutput("flush_next", 1'b1, 32'h44, 2'd1, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("flush_drain", 1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
`endif

    // Asynchronous reset between edges while FULL
    applyStimulus(1'b1, 32'h55, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h66, 1'b0);
    tick();
    checkOutput("arst_pre", 1'b1, 32'h55, 2'd2, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_now", 1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("arst_after", 1'b0, 32'h0, 2'd0, 1'b1, 1'b1);

    // Random back-pressure against an occupancy model and a FIFO scoreboard
    model_occ = 0;
    next_val  = 32'h1000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      iv   = (cyc < 340) ? logic'($urandom_range(0, 1)) : 1'b0;
      ordy = (cyc < 340) ? logic'($urandom_range(0, 1)) : 1'b1;
      applyStimulus(iv, next_val, ordy);
      #1;
      exp_rdy = (model_occ != 2);
      acc     = iv & exp_rdy;
      rel     = (model_occ != 0) & ordy;
      checkBit("rand.in_ready", in_ready, exp_rdy);
      checkBit("rand.out_valid", out_valid, model_occ != 0);
      if (rel) begin
        exp_d = sb.pop_front();
        checks++;
        assert (out_data === exp_d) else begin
          errors++;
          $error("[TB] FAIL rand.out_data observed %h expected %h", out_data, exp_d);
        end
      end
      if (acc) begin
        sb.push_back(next_val);
        next_val = next_val + 32'd1;
      end
      model_occ = model_occ + (acc ? 1 : 0) - (rel ? 1 : 0);
      tick();
      checks++;
      assert (occupancy === 2'(model_occ)) else begin
        errors++;
        $error("[TB] FAIL rand.occupancy observed %0d expected %0d", occupancy, model_occ);
      end
    end
    checks++;
    assert (sb.size() == 0 && model_occ == 0 && next_val > 32'h1000) else begin
      errors++;
      $error("[TB] FAIL rand.drain observed %0d pending expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
